flag_register: RTL and testbench
================================

# flag_register

Z80 flag register (F) that consumes the ALU status outputs (S, Z, H, P/V, N, C). It holds the architectural F byte, applies masked per-flag updates, and implements SCF/CCF and POP AF loads. It also provides the EX AF,AF' shadow bank and evaluates the eight Z80 condition codes for the sequencer (JP/JR/CALL/RET cc), with a registered request/valid handshake. It sits between the ALU status logic and the control FSM.

## Interface
- RESET_VALUE, 8'hFF, value loaded into active and shadow F on reset

- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- s_in, z_in, h_in, pv_in, n_in, c_in  input  1 each  ALU status flags
- alu_we  input  1  apply ALU flags this cycle
- flag_mask  input  8  per-bit write enable for alu_we, using F bit positions
- scf  input  1  set-carry-flag pulse
- ccf  input  1  complement-carry-flag pulse
- f_load  input  1  load F from f_din (POP AF / transfer)
- f_din  input  8  load data
- ex_af  input  1  swap active/shadow F (EX AF,AF')
- cond_req  input  1  condition evaluation request
- cond_code  input  3  0 NZ, 1 Z, 2 NC, 3 C, 4 PO, 5 PE, 6 P, 7 M
- f_out  output  8  active F register
- cond_valid  output  1  cond_true is valid this cycle
- cond_true  output  1  condition result

## Operation
- F layout: bit7 S, bit6 Z, bit5 X, bit4 H, bit3 X, bit2 P/V, bit1 N, bit0 C.
- ALU flags are mapped to their positions.
- Bits 5 and 3 change only through f_load or ex_af.
- The mask bits for positions 5 and 3 are ignored.
- Write source priority, one per cycle: f_load > ccf > scf > alu_we. Lower-priority requests in the same cycle are dropped.
- f_load: F ← f_din, all 8 bits.
- scf: C=1, H=0, N=0; other bits held.
- ccf: H=old C, C=~old C, N=0; other bits held.
- ccf and scf together: ccf wins.
- alu_we: F[i] ← mapped flag where flag_mask[i]=1; otherwise held. flag_mask=0 is a no-op.
- ex_af alone: active ↔ shadow swap.
- ex_af together with a write: next shadow = old active. Next active = write source applied to old shadow, where "old C" for ccf means shadow C.
- Condition evaluation uses the active F sampled in the cond_req cycle, before any same-cycle write or swap.
- Condition meanings: NZ=!Z, Z=Z, NC=!C, C=C, PO=!PV, PE=PV, P=!S, M=S.
- Requests may be issued every cycle; each produces exactly one result.

## Timing
- Reset, asynchronous assert: active F = shadow F = RESET_VALUE, f_out = RESET_VALUE, cond_valid = 0, cond_true = 0. Reset is released synchronously to clk.
- All writes and swaps take effect at the rising edge and are visible on f_out the next cycle. f_out is a register with no combinational path from the inputs.
- Condition latency is 1 cycle: cond_req at edge N gives cond_valid=1 and cond_true after edge N, for one cycle.
- cond_valid deasserts when there is no request. cond_true holds its last value while cond_valid=0.
- Reset asserted mid-request: cond_valid drops immediately and the pending result is discarded.

## Configuration
- FLAG_SHADOW_EN defined: shadow bank present, ex_af behaves as above.
- FLAG_SHADOW_EN undefined: no shadow storage. ex_af is ignored and writes proceed normally in that cycle. Reset and all other behaviour are unchanged.

## Test plan
- Reset release -> f_out=8'hFF, cond_valid=0; cond_req with code 1 (Z) -> next cycle cond_valid=1, cond_true=1.
- f_load f_din=8'h00, then alu_we with flag_mask=8'hFF, s=1, z=0, h=1, pv=1, n=0, c=1 -> f_out=8'h95, bits 5 and 3 still 0.
- F=8'h01; ccf -> f_out=8'h10; scf -> f_out=8'h01; ccf+scf+alu_we in the same cycle -> f_out=8'h10.
- F=8'h40, shadow=8'hFF; ex_af -> f_out=8'hFF; ex_af again -> 8'h40. ex_af together with f_load 8'h12 -> f_out=8'h12, then ex_af -> 8'h40. With FLAG_SHADOW_EN undefined, ex_af -> f_out unchanged.
- F=8'h84; back-to-back cond_req with codes 7 (M), 4 (PO), 6 (P) -> cond_true 1, 0, 0 on consecutive cycles. A same-cycle f_load 8'h00 during the first request does not affect its result.
- cond_req issued, reset_n asserted before the next edge -> cond_valid=0 and f_out=8'hFF immediately.

Source files
------------

// File: rtl/flag_register.sv
// flag_register: Z80 F register with masked ALU updates, SCF/CCF, F load,
// an optional EX AF,AF' shadow bank and a registered condition-code evaluator.
// Optional feature macro: FLAG_SHADOW_EN (shadow F bank; ex_af ignored when undefined).
module flag_register #(
    parameter logic [7:0] RESET_VALUE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_in,
    input  logic       z_in,
    input  logic       h_in,
    input  logic       pv_in,
    input  logic       n_in,
    input  logic       c_in,
    input  logic       alu_we,
    input  logic [7:0] flag_mask,
    input  logic       scf,
    input  logic       ccf,
    input  logic       f_load,
    input  logic [7:0] f_din,
    input  logic       ex_af,
    input  logic       cond_req,
    input  logic [2:0] cond_code,
    output logic [7:0] f_out,
    output logic       cond_valid,
    output logic       cond_true
);

    localparam int B_S  = 7;
    localparam int B_Z  = 6;
    localparam int B_H  = 4;
    localparam int B_PV = 2;
    localparam int B_N  = 1;
    localparam int B_C  = 0;

    // Undocumented bits 5 and 3 are never writable through the ALU path.
    localparam logic [7:0] ALU_WMASK = 8'b1101_0111;

    logic [7:0] f_q, f_d;
    logic [7:0] base;
    logic [7:0] alu_vec;
    logic [7:0] mask_eff;
    logic       cond_valid_q;
    logic       cond_true_q, cond_true_d;

    assign alu_vec  = {s_in, z_in, 1'b0, h_in, 1'b0, pv_in, n_in, c_in};
    assign mask_eff = flag_mask & ALU_WMASK;

`ifdef FLAG_SHADOW_EN
    logic [7:0] shadow_q, shadow_d;

    // A swap makes the write act on the old shadow; the old active becomes shadow.
    always_comb begin
        base     = ex_af ? shadow_q : f_q;
        shadow_d = ex_af ? f_q : shadow_q;
    end

    // Shadow F storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) shadow_q <= RESET_VALUE;
        else          shadow_q <= shadow_d;
    end
`else
    logic unused_ex_af;
    assign unused_ex_af = ex_af;

    // Without a shadow bank every write acts on the active F.
    always_comb begin
        base = f_q;
    end
`endif

    // Next active F: one write source per cycle, f_load > ccf > scf > alu_we.
    always_comb begin
        f_d = base;
        if (f_load) begin
            f_d = f_din;
        end else if (ccf) begin
            f_d[B_H] = base[B_C];
            f_d[B_C] = ~base[B_C];
            f_d[B_N] = 1'b0;
        end else if (scf) begin
            f_d[B_C] = 1'b1;
            f_d[B_H] = 1'b0;
            f_d[B_N] = 1'b0;
        end else if (alu_we) begin
            f_d = (base & ~mask_eff) | (alu_vec & mask_eff);
        end
    end

    // Condition result from the pre-write active F; held when no request.
    always_comb begin
        cond_true_d = cond_true_q;
        if (cond_req) begin
            case (cond_code)
                3'd0:    cond_true_d = ~f_q[B_Z];
                3'd1:    cond_true_d =  f_q[B_Z];
                3'd2:    cond_true_d = ~f_q[B_C];
                3'd3:    cond_true_d =  f_q[B_C];
                3'd4:    cond_true_d = ~f_q[B_PV];
                3'd5:    cond_true_d =  f_q[B_PV];
                3'd6:    cond_true_d = ~f_q[B_S];
                default: cond_true_d =  f_q[B_S];
            endcase
        end
    end

    // Active F and condition result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_q          <= RESET_VALUE;
            cond_valid_q <= 1'b0;
            cond_true_q  <= 1'b0;
        end else begin
            f_q          <= f_d;
            cond_valid_q <= cond_req;
            cond_true_q  <= cond_true_d;
        end
    end

    assign f_out      = f_q;
    assign cond_valid = cond_valid_q;
    assign cond_true  = cond_true_q;

endmodule

// File: tb/tb_flag_register.sv
// Testbench for flag_register: table of per-cycle vectors plus reset corner cases.
module tb_flag_register;

`ifdef FLAG_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_in = 0, z_in = 0, h_in = 0, pv_in = 0, n_in = 0, c_in = 0;
    logic       alu_we = 0;
    logic [7:0] flag_mask = 8'h00;
    logic       scf = 0, ccf = 0, f_load = 0;
    logic [7:0] f_din = 8'h00;
    logic       ex_af = 0, cond_req = 0;
    logic [2:0] cond_code = 3'd0;
    logic [7:0] f_out;
    logic       cond_valid, cond_true;

    int checks = 0;
    int failures = 0;

    flag_register dut (
        .clk(clk), .reset_n(reset_n),
        .s_in(s_in), .z_in(z_in), .h_in(h_in), .pv_in(pv_in), .n_in(n_in), .c_in(c_in),
        .alu_we(alu_we), .flag_mask(flag_mask), .scf(scf), .ccf(ccf),
        .f_load(f_load), .f_din(f_din), .ex_af(ex_af),
        .cond_req(cond_req), .cond_code(cond_code),
        .f_out(f_out), .cond_valid(cond_valid), .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] din;
        logic       we;
        logic [7:0] mask;
        logic [5:0] fl;     // {s,z,h,pv,n,c}
        logic       sc;
        logic       cc;
        logic       ex;
        logic       rq;
        logic [2:0] code;
        logic [7:0] exp_f;
        logic       exp_cv;
        logic       exp_ct;
    } vec_t;

    vec_t vecs[24];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_we = 0; flag_mask = 8'h00; scf = 0; ccf = 0; f_load = 0; f_din = 8'h00;
        ex_af = 0; cond_req = 0; cond_code = 3'd0;
        {s_in, z_in, h_in, pv_in, n_in, c_in} = 6'b0;
    endtask

    function automatic vec_t mk(input logic ld, input logic [7:0] din, input logic we,
                                input logic [7:0] mask, input logic [5:0] fl,
                                input logic sc, input logic cc, input logic ex,
                                input logic rq, input logic [2:0] code,
                                input logic [7:0] ef, input logic ecv, input logic ect);
        vec_t v;
        v.ld = ld; v.din = din; v.we = we; v.mask = mask; v.fl = fl;
        v.sc = sc; v.cc = cc; v.ex = ex; v.rq = rq; v.code = code;
        v.exp_f = ef; v.exp_cv = ecv; v.exp_ct = ect;
        return v;
    endfunction

    initial begin
        //           ld din    we mask   fl        sc cc ex rq code exp_f              cv ct
        vecs[0]  = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 0, 1, 3'd1, 8'hFF,             1, 1);
        vecs[1]  = mk(1, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 0, 0, 3'd0, 8'h00,             0, 1);
        vecs[2]  = mk(0, 8'h00, 1, 8'hFF, 6'b101101, 0, 0, 0, 0, 3'd0, 8'h95,             0, 1);
        vecs[3]  = mk(0, 8'h00, 1, 8'h28, 6'b111111, 0, 0, 0, 0, 3'd0, 8'h95,             0, 1);
        vecs[4]  = mk(0, 8'h00, 1, 8'h00, 6'b111111, 0, 0, 0, 0, 3'd0, 8'h95,             0, 1);
        vecs[5]  = mk(0, 8'h00, 1, 8'h42, 6'b010010, 0, 0, 0, 1, 3'd0, 8'hD7,             1, 1);
        vecs[6]  = mk(1, 8'h01, 0, 8'h00, 6'b000000, 0, 0, 0, 1, 3'd2, 8'h01,             1, 0);
        vecs[7]  = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 1, 0, 0, 3'd0, 8'h10,             0, 0);
        vecs[8]  = mk(0, 8'h00, 0, 8'h00, 6'b000000, 1, 0, 0, 0, 3'd0, 8'h01,             0, 0);
        vecs[9]  = mk(0, 8'h00, 1, 8'hFF, 6'b111111, 1, 1, 0, 0, 3'd0, 8'h10,             0, 0);
        vecs[10] = mk(1, 8'h40, 1, 8'hFF, 6'b111111, 1, 1, 0, 0, 3'd0, 8'h40,             0, 0);
        vecs[11] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 1, 0, 3'd0, SH ? 8'hFF : 8'h40, 0, 0);
        vecs[12] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 1, 0, 3'd0, 8'h40,             0, 0);
        vecs[13] = mk(1, 8'h12, 0, 8'h00, 6'b000000, 0, 0, 1, 0, 3'd0, 8'h12,             0, 0);
        vecs[14] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 1, 0, 3'd0, SH ? 8'h40 : 8'h12, 0, 0);
        vecs[15] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 1, 1, 0, 3'd0, 8'h01,             0, 0);
        vecs[16] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 1, 0, 3'd0, SH ? 8'h40 : 8'h01, 0, 0);
        vecs[17] = mk(1, 8'h84, 0, 8'h00, 6'b000000, 0, 0, 0, 0, 3'd0, 8'h84,             0, 0);
        vecs[18] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 0, 1, 3'd7, 8'h84,             1, 1);
        vecs[19] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 0, 1, 3'd4, 8'h84,             1, 0);
        vecs[20] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 0, 1, 3'd6, 8'h84,             1, 0);
        vecs[21] = mk(1, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 0, 1, 3'd7, 8'h00,             1, 1);
        vecs[22] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 0, 1, 3'd5, 8'h00,             1, 0);
        vecs[23] = mk(0, 8'h00, 0, 8'h00, 6'b000000, 0, 0, 0, 0, 3'd0, 8'h00,             0, 0);

        idle();
        #12;
        chk8("reset_f", f_out, 8'hFF);
        chk1("reset_cv", cond_valid, 1'b0);
        chk1("reset_ct", cond_true, 1'b0);

        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            f_load = vecs[i].ld; f_din = vecs[i].din; alu_we = vecs[i].we;
            flag_mask = vecs[i].mask;
            {s_in, z_in, h_in, pv_in, n_in, c_in} = vecs[i].fl;
            scf = vecs[i].sc; ccf = vecs[i].cc; ex_af = vecs[i].ex;
            cond_req = vecs[i].rq; cond_code = vecs[i].code;
            @(negedge clk);
            chk8($sformatf("vec%0d_f", i), f_out, vecs[i].exp_f);
            chk1($sformatf("vec%0d_cv", i), cond_valid, vecs[i].exp_cv);
            chk1($sformatf("vec%0d_ct", i), cond_true, vecs[i].exp_ct);
        end

        // Reset asserted while a request is pending: output drops at once.
        f_load = 1'b1; f_din = 8'h55;
        @(negedge clk);
        idle();
        cond_req = 1'b1; cond_code = 3'd1;       // Z of 55 -> 1
        @(negedge clk);
        chk1("pre_rst_cv", cond_valid, 1'b1);
        chk1("pre_rst_ct", cond_true, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk1("async_rst_cv", cond_valid, 1'b0);
        chk1("async_rst_ct", cond_true, 1'b0);
        chk8("async_rst_f", f_out, 8'hFF);
        @(negedge clk);
        chk1("held_rst_cv", cond_valid, 1'b0);
        idle();
        reset_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_cv", cond_valid, 1'b0);

        // Shadow also reloads on reset: load active, then swap.
        f_load = 1'b1; f_din = 8'h3C;
        @(negedge clk);
        idle();
        ex_af = 1'b1;
        @(negedge clk);
        idle();
        chk8("shadow_reset_swap", f_out, SH ? 8'hFF : 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
